stopwatch_ctrl: RTL and testbench
=================================

Name: stopwatch_ctrl

Overview:
Control front-end that sits directly upstream of the tick_gen counter chain in the stopwatch/clock datapath.
- Generates the free-running base tick that feeds the first tick_gen's i_tick.
- Debounces the two raw push-buttons (run/stop, clear).
- Runs the RUN/PAUSE/IDLE state machine that drives every tick_gen's i_run_en, plus a one-cycle clear pulse.
- The clear pulse is OR'd into the tick_gen counter reset path.

Parameters:
- P_TICK_DIV, 100000, clk cycles per base tick (100 MHz to 1 kHz); legal range is 1 or more.
- P_DIV_BIT, 17, prescaler counter width; must satisfy 2^P_DIV_BIT >= P_TICK_DIV.
- P_DB_CNT, 20, consecutive base ticks a button level must be stable before it is accepted; legal range is 1 or more.
- P_DB_BIT, 5, debounce counter width; must satisfy 2^P_DB_BIT > P_DB_CNT.

Ports:
- clk  input  1  system clock; single clock domain.
- reset  input  1  synchronous, active-low reset (reset==0 resets on the clk rising edge).
- i_btn_run  input  1  raw run/stop button, active-high, asynchronous to clk.
- i_btn_clr  input  1  raw clear button, active-high, asynchronous to clk.
- o_tick  output  1  base tick, one clk wide, every P_TICK_DIV cycles.
- o_run_en  output  1  high while state==RUN.
- o_clear  output  1  one-cycle pulse requesting a counter clear.
- o_state  output  2  current state encoding, for display/debug.

Behaviour:
- Reset values: o_tick=0, o_run_en=0, o_clear=0, o_state=IDLE. Prescaler, debounce counters, synchroniser flops and debounced levels are all cleared to 0. Reset overrides all other activity at any time, including mid-debounce.
- Prescaler:
  - cnt counts 0..P_TICK_DIV-1 and wraps.
  - o_tick is registered: it is 1 in the cycle after cnt==P_TICK_DIV-1, otherwise 0.
  - After reset release, the first o_tick appears on cycle P_TICK_DIV.
  - P_TICK_DIV==1 gives o_tick=1 every cycle after the first post-reset cycle.
  - The prescaler is free-running and independent of state.
- Button synchroniser: 2-flop synchroniser per button. Synchroniser latency is 2 clk.
- Debounce, per button:
  - Evaluated only on cycles where the internal tick is 1.
  - If the synchronised level != debounced level, the counter increments. Otherwise the counter is cleared.
  - When the counter reaches P_DB_CNT-1 on a tick, the debounced level takes the synchronised level and the counter clears.
  - Any return to the old level on a tick before acceptance clears the counter, so a glitch shorter than P_DB_CNT ticks is rejected.
  - A press event is a one-clk pulse on the 0-to-1 transition of the debounced level. Releases generate no event.
- FSM states (package constants): IDLE=2'b00, RUN=2'b01, PAUSE=2'b10; 2'b11 is illegal and recovers to IDLE on the next cycle.
- FSM transitions:
  - IDLE: run_evt goes to RUN. clr_evt stays IDLE and pulses o_clear.
  - RUN: run_evt goes to PAUSE. clr_evt is ignored.
  - PAUSE: run_evt goes to RUN. clr_evt goes to IDLE and pulses o_clear.
- Simultaneous run_evt and clr_evt in the same cycle:
  - IDLE/PAUSE: clear wins, giving IDLE plus o_clear; the run press is dropped.
  - RUN: run wins, giving PAUSE; no clear.
- Output timing:
  - An event in cycle N means the state register and o_clear update at the edge ending cycle N.
  - o_run_en and o_state are decoded from the state register and are valid from cycle N+1.
  - o_clear is high for exactly cycle N+1.
- Button held through reset: after reset release it is accepted as a fresh press after P_DB_CNT ticks plus 2 clk synchroniser latency.

Decomposition:
- stopwatch_pkg: state encodings (ST_IDLE, ST_RUN, ST_PAUSE) and the state width constant (2).
- Sub-module btn_debounce, instantiated twice. It contains the synchroniser, the debounce counter, the debounced level and the rising-edge press pulse.
  - Ports: clk, reset, i_tick, i_btn, o_level, o_press.
  - Parameters: P_DB_CNT, P_DB_BIT.
- The prescaler and FSM stay in the top module.

Test Plan:
Bench parameters: P_TICK_DIV=4, P_DB_CNT=3.
1. Reset and prescaler: hold reset=0 for 3 clk, then release. All outputs are 0 and o_state=00 during reset. o_tick pulses on cycles 4, 8, 12, ... after release and is exactly 1 clk wide.
2. Run press: raise i_btn_run and hold for 30 clk. Exactly one press event occurs; o_run_en rises about 14 clk after the button edge (2 synchroniser clk plus 3 ticks); o_state=01. Releasing the button causes no state change.
3. Glitch rejection: from IDLE, hold i_btn_run high for 2 ticks (8 clk), then low. No event, o_run_en stays 0, o_state stays 00.
4. Pause and clear: in RUN, press run, then o_state=10 and o_run_en=0. Then press clr: o_state=00 and o_clear=1 for exactly one clk. Pressing clr again in IDLE gives another single o_clear pulse with state still 00.
5. Simultaneous presses: both buttons rise on the same clk.
   - In PAUSE: o_state=00 with one o_clear pulse.
   - In RUN: o_state=10 with no o_clear.
6. Reset mid-operation: in RUN with i_btn_clr mid-debounce, assert reset=0 for 1 clk. Outputs return to reset values and no o_clear occurs. If i_btn_run is held through reset, a run press is recognised P_DB_CNT ticks after release and gives o_state=01.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch control front-end.
// Holds the FSM state width and the state encodings.
package stopwatch_pkg;

    localparam int ST_W = 2;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10
    } state_t;

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button inputs and status outputs of stopwatch_ctrl.
// master: drives i_btn_run/i_btn_clr, observes o_tick/o_run_en/o_clear/o_state.
// slave:  the controller side of the same signals.
interface stopwatch_ctrl_if;
    import stopwatch_pkg::*;

    logic            i_btn_run;
    logic            i_btn_clr;
    logic            o_tick;
    logic            o_run_en;
    logic            o_clear;
    logic [ST_W-1:0] o_state;

    modport master (
        output i_btn_run,
        output i_btn_clr,
        input  o_tick,
        input  o_run_en,
        input  o_clear,
        input  o_state
    );

    modport slave (
        input  i_btn_run,
        input  i_btn_clr,
        output o_tick,
        output o_run_en,
        output o_clear,
        output o_state
    );

endinterface

// File: rtl/stopwatch_ctrl_btn_debounce.sv
// Two-flop synchroniser plus tick-based debounce for one raw button.
// Ports: clk, reset (sync, active-low), i_tick (debounce strobe),
//        i_btn (raw level), o_level (debounced), o_press (1-clk rise pulse).
module btn_debounce #(
    parameter int P_DB_CNT = 20,
    parameter int P_DB_BIT = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic i_tick,
    input  logic i_btn,
    output logic o_level,
    output logic o_press
);

    localparam logic [P_DB_BIT-1:0] LP_LAST = P_DB_BIT'(P_DB_CNT - 1);

    logic                r_sync1;
    logic                r_sync2;
    logic                r_level;
    logic                r_press;
    logic [P_DB_BIT-1:0] r_cnt;

    logic w_diff;
    logic w_accept;

    assign w_diff   = r_sync2 ^ r_level;
    // The level has differed for P_DB_CNT consecutive ticks, this one included.
    assign w_accept = i_tick & w_diff & (r_cnt == LP_LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_press <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            // Only a 0->1 acceptance is a press; releases are silent.
            r_press <= w_accept & r_sync2;
            if (w_accept) begin
                r_level <= r_sync2;
            end
            if (i_tick) begin
                if (!w_diff || w_accept) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign o_level = r_level;
    assign o_press = r_press;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control front-end: base-tick prescaler, button debounce, RUN/PAUSE/IDLE FSM.
// Ports: clk, reset (sync, active-low), sw (slave modport: buttons in, tick/run_en/clear/state out).
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int P_TICK_DIV = 100000,
    parameter int P_DIV_BIT  = 17,
    parameter int P_DB_CNT   = 20,
    parameter int P_DB_BIT   = 5
) (
    input  logic            clk,
    input  logic            reset,
    stopwatch_ctrl_if.slave sw
);

    localparam logic [P_DIV_BIT-1:0] LP_DIV_LAST = P_DIV_BIT'(P_TICK_DIV - 1);

    logic [P_DIV_BIT-1:0] r_cnt;
    logic                 r_tick;
    state_t               r_state;
    logic                 r_clear;

    state_t w_state_nxt;
    logic   w_clear_nxt;
    logic   w_run_evt;
    logic   w_clr_evt;
    logic   w_run_lvl;
    logic   w_clr_lvl;

    // Free-running prescaler; the tick is registered off the terminal count.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= (r_cnt == LP_DIV_LAST);
            r_cnt  <= (r_cnt == LP_DIV_LAST) ? '0 : r_cnt + 1'b1;
        end
    end

    btn_debounce #(
        .P_DB_CNT (P_DB_CNT),
        .P_DB_BIT (P_DB_BIT)
    ) u_db_run (
        .clk     (clk),
        .reset   (reset),
        .i_tick  (r_tick),
        .i_btn   (sw.i_btn_run),
        .o_level (w_run_lvl),
        .o_press (w_run_evt)
    );

    btn_debounce #(
        .P_DB_CNT (P_DB_CNT),
        .P_DB_BIT (P_DB_BIT)
    ) u_db_clr (
        .clk     (clk),
        .reset   (reset),
        .i_tick  (r_tick),
        .i_btn   (sw.i_btn_clr),
        .o_level (w_clr_lvl),
        .o_press (w_clr_evt)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_clear <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_clear <= w_clear_nxt;
        end
    end

    // Clear beats run outside RUN; inside RUN clear is ignored.
    always_comb begin
        w_state_nxt = r_state;
        w_clear_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_clr_evt) begin
                    w_clear_nxt = 1'b1;
                end else if (w_run_evt) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_run_evt) begin
                    w_state_nxt = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (w_clr_evt) begin
                    w_state_nxt = ST_IDLE;
                    w_clear_nxt = 1'b1;
                end else if (w_run_evt) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign sw.o_tick   = r_tick;
    assign sw.o_run_en = (r_state == ST_RUN);
    assign sw.o_clear  = r_clear;
    assign sw.o_state  = r_state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: directed scenarios plus random
// button activity, compared every cycle against a behavioural model.
module tb_stopwatch_ctrl;

    localparam int DIV = 4;
    localparam int DB  = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    stopwatch_ctrl_if sw ();

    stopwatch_ctrl #(
        .P_TICK_DIV (DIV),
        .P_DIV_BIT  (3),
        .P_DB_CNT   (DB),
        .P_DB_BIT   (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .sw    (sw.slave)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: index 0 = run button, 1 = clear button.
    // State: 0 idle, 1 run, 2 pause.
    int m_edges = 0;
    bit m_tick = 0;
    bit m_s1 [2] = '{0, 0};
    bit m_s2 [2] = '{0, 0};
    bit m_lvl [2] = '{0, 0};
    int m_stab [2] = '{0, 0};
    bit m_prs [2] = '{0, 0};
    int m_st = 0;
    bit m_clr = 0;
    bit chk_en = 0;

    always @(posedge clk) begin
        bit btn [2];
        btn[0] = sw.i_btn_run;
        btn[1] = sw.i_btn_clr;
        if (!reset) begin
            m_edges = 0;
            m_tick  = 0;
            m_st    = 0;
            m_clr   = 0;
            for (int b = 0; b < 2; b++) begin
                m_s1[b] = 0; m_s2[b] = 0; m_lvl[b] = 0;
                m_stab[b] = 0; m_prs[b] = 0;
            end
        end else begin
            // FSM reacts to the press flags visible during the ending cycle.
            m_clr = 0;
            if (m_prs[1] && m_st != 1) begin
                m_st  = 0;
                m_clr = 1;
            end else if (m_prs[0]) begin
                m_st = (m_st == 1) ? 2 : 1;
            end
            for (int b = 0; b < 2; b++) begin
                m_prs[b] = 0;
                if (m_tick) begin
                    if (m_s2[b] != m_lvl[b]) begin
                        m_stab[b]++;
                        if (m_stab[b] == DB) begin
                            m_lvl[b]  = m_s2[b];
                            m_stab[b] = 0;
                            m_prs[b]  = m_s2[b];
                        end
                    end else begin
                        m_stab[b] = 0;
                    end
                end
                m_s2[b] = m_s1[b];
                m_s1[b] = btn[b];
            end
            m_edges++;
            m_tick = (m_edges % DIV == 0);
        end
    end

    int clr_cnt = 0;
    int rise_cnt = 0;
    logic prev_run = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("tick", sw.o_tick, m_tick);
            chk("run_en", sw.o_run_en, m_st == 1);
            chk("clear", sw.o_clear, m_clr);
            chk("state", sw.o_state, m_st[1:0]);
        end
        if (sw.o_clear === 1'b1) clr_cnt++;
        if (sw.o_run_en === 1'b1 && prev_run === 1'b0) rise_cnt++;
        prev_run = sw.o_run_en;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input bit r, input bit c);
        sw.i_btn_run = r;
        sw.i_btn_clr = c;
        wait_cyc(30);
        sw.i_btn_run = 0;
        sw.i_btn_clr = 0;
        wait_cyc(30);
    endtask

    task automatic do_reset(input int n);
        reset = 0;
        wait_cyc(n);
        reset = 1;
    endtask

    initial begin
        int c0;
        sw.i_btn_run = 0;
        sw.i_btn_clr = 0;
        // 1: reset and prescaler
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_en = 1;
            chk("rst_tick", sw.o_tick, 0);
            chk("rst_run", sw.o_run_en, 0);
            chk("rst_clr", sw.o_clear, 0);
            chk("rst_state", sw.o_state, 0);
        end
        reset = 1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            chk("tick_pos", sw.o_tick, (i % DIV) == 0);
        end
        // 3: glitch rejection (two ticks)
        sw.i_btn_run = 1;
        wait_cyc(8);
        sw.i_btn_run = 0;
        wait_cyc(20);
        chk("glitch_state", sw.o_state, 2'b00);
        chk("glitch_run", sw.o_run_en, 0);
        // 2: run press, single event, release silent
        rise_cnt = 0;
        sw.i_btn_run = 1;
        wait_cyc(30);
        chk("run_state", sw.o_state, 2'b01);
        chk("run_en", sw.o_run_en, 1);
        sw.i_btn_run = 0;
        wait_cyc(30);
        chk("run_rel_state", sw.o_state, 2'b01);
        chk("run_rises", rise_cnt, 1);
        // 4: pause, clear, clear again
        press(1, 0);
        chk("pause_state", sw.o_state, 2'b10);
        chk("pause_run", sw.o_run_en, 0);
        c0 = clr_cnt;
        press(0, 1);
        chk("clr_state", sw.o_state, 2'b00);
        chk("clr_pulses", clr_cnt - c0, 1);
        c0 = clr_cnt;
        press(0, 1);
        chk("clr2_state", sw.o_state, 2'b00);
        chk("clr2_pulses", clr_cnt - c0, 1);
        // 5: simultaneous presses in PAUSE then RUN
        press(1, 0);
        press(1, 0);
        c0 = clr_cnt;
        press(1, 1);
        chk("both_pause_state", sw.o_state, 2'b00);
        chk("both_pause_clr", clr_cnt - c0, 1);
        press(1, 0);
        c0 = clr_cnt;
        press(1, 1);
        chk("both_run_state", sw.o_state, 2'b10);
        chk("both_run_clr", clr_cnt - c0, 0);
        // 6: reset mid-debounce, then run held through reset
        press(1, 0);
        chk("pre_rst_state", sw.o_state, 2'b01);
        c0 = clr_cnt;
        sw.i_btn_clr = 1;
        wait_cyc(6);
        sw.i_btn_clr = 0;
        do_reset(1);
        chk("mid_rst_state", sw.o_state, 2'b00);
        chk("mid_rst_run", sw.o_run_en, 0);
        wait_cyc(30);
        chk("mid_rst_noclr", clr_cnt - c0, 0);
        sw.i_btn_run = 1;
        wait_cyc(5);
        do_reset(1);
        wait_cyc(2 + DB * DIV + DIV + 4);
        chk("held_run_state", sw.o_state, 2'b01);
        sw.i_btn_run = 0;
        wait_cyc(20);
        // Random button activity with occasional resets.
        for (int k = 0; k < 300; k++) begin
            sw.i_btn_run = 1'($urandom_range(0, 1));
            sw.i_btn_clr = 1'($urandom_range(0, 1));
            wait_cyc($urandom_range(1, 24));
            if ($urandom_range(0, 49) == 0) do_reset($urandom_range(1, 3));
        end
        sw.i_btn_run = 0;
        sw.i_btn_clr = 0;
        wait_cyc(40);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
